half_word_serializer: RTL and testbench
=======================================

Name: half_word_serializer

Overview:
- Producer-side counterpart of the pipeline's half-select mux.
- Accepts one 2*NBITS-bit word per valid/ready handshake and emits it as two NBITS-bit halves on consecutive output handshakes.
- Drives out_half alongside each half, so a downstream selector/reassembler knows which half is on the bus (1 = msb half, 0 = lsb half).
- Sits between a wide pipeline stage and a narrow NBITS-wide link; a one-word pending buffer sustains one half per cycle.

Parameters:
- NBITS, 7, width of one half and of out_data.
- MSB_FIRST, 1, 1 = emit msb half first; 0 = emit lsb half first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- in_data  input  2*NBITS  word to serialize; msb half = in_data[2*NBITS-1:NBITS], lsb half = in_data[NBITS-1:0].
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept a word this cycle.
- out_data  output  NBITS  current half.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_half  output  1  1 = out_data is msb half, 0 = lsb half.
- out_last  output  1  out_data is the second half of its word.
- word_count  output  16  number of fully emitted words.

Behaviour:
- Storage: cur (2*NBITS), pend (2*NBITS), pend_valid. FSM states: EMPTY, FIRST, SECOND.
- Handshakes: in_acc = in_valid & in_ready; out_acc = out_valid & out_ready.
- in_ready = ~pend_valid (purely from registered state).
- out_valid = (state != EMPTY).
- Outputs in FIRST/SECOND:
  - out_half = MSB_FIRST in FIRST, ~MSB_FIRST in SECOND.
  - out_data = msb or lsb half of cur, selected by out_half.
  - out_last = (state == SECOND).
- Outputs in EMPTY: out_data = 0, out_half = 0, out_last = 0.
- Output stability: out_data, out_half and out_last hold while out_valid & ~out_ready.
- EMPTY:
  - in_acc → cur <= in_data, FIRST.
  - Latency: word accepted at edge t, first half valid after edge t, i.e. in cycle t+1.
- FIRST:
  - out_acc → SECOND.
  - in_acc → pend <= in_data, pend_valid <= 1.
- SECOND with out_acc (word_count increments, wrapping 16'hFFFF → 0):
  - If pend_valid: cur <= pend, FIRST. If in_acc in the same cycle, pend <= in_data and pend_valid stays 1; otherwise pend_valid <= 0.
  - Else if in_acc: cur <= in_data directly, FIRST (bypasses pend).
  - Else: EMPTY.
- SECOND without out_acc: in_acc → pend, same as in FIRST.
- Throughput: back-to-back words with out_ready held high give one half per cycle and no bubbles. in_ready is high in at least 1 of every 2 cycles.
- Backpressure: while pend_valid = 1, in_ready = 0. A word offered then is neither consumed nor corrupted.
- Reset (any cycle, including mid-word):
  - state EMPTY, pend_valid 0, cur 0, pend 0, word_count 0.
  - Outputs after reset: out_valid 0, out_data 0, out_half 0, out_last 0, in_ready 1.
  - Partially emitted and pending words are discarded, with no further output of them.
- rst has priority over every simultaneous handshake.

Test Plan:
- Reset, then single word: NBITS=7, MSB_FIRST=1, in_data=14'h2A55, out_ready=1 → next cycle out_data=7'h54, out_half=1, out_last=0; following cycle out_data=7'h55, out_half=0, out_last=1; then out_valid=0, word_count=1.
- MSB_FIRST=0, same word → 7'h55 (out_half=0) then 7'h54 (out_half=1, out_last=1).
- Streaming: in_valid held high with words 14'h0001, 14'h3FFF, 14'h1234, out_ready=1 → six consecutive halves 00,01,7F,7F,24,34 with no gaps; in_ready toggles; word_count=3.
- Backpressure: out_ready=0 for 5 cycles after the first word, with a second word offered → out_data holds 7'h54; second word goes to pend; in_ready=0 while a third word is offered; release yields correct order with no loss or duplication.
- Reset mid-operation: assert rst while in SECOND with pend_valid=1 → next cycle out_valid=0, in_ready=1, word_count=0; a new word afterwards serializes normally.
- Counter wrap: preload by streaming 65536 words (or force) → word_count wraps to 0 on the 65536th completion.

Source files
------------

// File: rtl/half_word_serializer.sv
// -----------------------------------------------------------------------------
// half_word_serializer
//
// Takes one 2*NBITS-bit word per input handshake and sends it out as two
// NBITS-bit halves on consecutive output handshakes. A one-word pending
// buffer lets the next word be taken while the current one is still going
// out, so a steady stream runs at one half per cycle.
//
// Parameters
//   NBITS      width of one half (and of out_data)
//   MSB_FIRST  1 = msb half goes out first, 0 = lsb half first
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   in_data     word to serialize (msb half = upper NBITS bits)
//   in_valid    in_data valid
//   in_ready    a word can be taken this cycle
//   out_data    current half (0 while idle)
//   out_valid   out_data valid
//   out_ready   consumer takes out_data this cycle
//   out_half    1 = out_data is the msb half, 0 = lsb half
//   out_last    out_data is the second half of its word
//   word_count  number of fully emitted words (wraps at 16 bits)
// -----------------------------------------------------------------------------
module half_word_serializer #(
   parameter int NBITS     = 7,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [2*NBITS-1:0] in_data,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [NBITS-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_half,
   output logic               out_last,
   output logic [15:0]        word_count
);

   typedef enum logic [1:0] {
      S_EMPTY  = 2'd0,
      S_FIRST  = 2'd1,
      S_SECOND = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [2*NBITS-1:0] r_cur;
   logic [2*NBITS-1:0] w_cur_nxt;
   logic [2*NBITS-1:0] r_pend;
   logic [2*NBITS-1:0] w_pend_nxt;
   logic               r_pend_valid;
   logic               w_pend_valid_nxt;
   logic [15:0]        r_word_count;
   logic               w_word_done;

   logic               w_in_acc;
   logic               w_out_acc;
   logic               w_busy;
   logic               w_half_sel;

   // Ready depends only on registered state so it never combinationally
   // follows in_valid or out_ready.
   assign w_busy    = (r_state != S_EMPTY);
   assign w_in_acc  = in_valid & ~r_pend_valid;
   assign w_out_acc = w_busy & out_ready;

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_EMPTY;
         r_cur        <= '0;
         r_pend       <= '0;
         r_pend_valid <= 1'b0;
         r_word_count <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_cur        <= w_cur_nxt;
         r_pend       <= w_pend_nxt;
         r_pend_valid <= w_pend_valid_nxt;
         if (w_word_done) begin
            r_word_count <= r_word_count + 16'd1;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt      = r_state;
      w_cur_nxt        = r_cur;
      w_pend_nxt       = r_pend;
      w_pend_valid_nxt = r_pend_valid;
      w_word_done      = 1'b0;

      case (r_state)
         S_EMPTY: begin
            // pend is always empty here, so every offered word is taken
            if (w_in_acc) begin
               w_cur_nxt   = in_data;
               w_state_nxt = S_FIRST;
            end
         end

         S_FIRST: begin
            if (w_out_acc) begin
               w_state_nxt = S_SECOND;
            end
            if (w_in_acc) begin
               w_pend_nxt       = in_data;
               w_pend_valid_nxt = 1'b1;
            end
         end

         S_SECOND: begin
            if (w_out_acc) begin
               w_word_done = 1'b1;
               if (r_pend_valid) begin
                  // w_in_acc is impossible here (ready is low while pend
                  // holds a word), so pend simply drains into cur.
                  w_cur_nxt        = r_pend;
                  w_state_nxt      = S_FIRST;
                  w_pend_valid_nxt = 1'b0;
                  if (w_in_acc) begin
                     w_pend_nxt       = in_data;
                     w_pend_valid_nxt = 1'b1;
                  end
               end else if (w_in_acc) begin
                  // nothing pending: new word goes straight to cur so the
                  // stream keeps one half per cycle
                  w_cur_nxt   = in_data;
                  w_state_nxt = S_FIRST;
               end else begin
                  w_state_nxt = S_EMPTY;
               end
            end else if (w_in_acc) begin
               w_pend_nxt       = in_data;
               w_pend_valid_nxt = 1'b1;
            end
         end

         default: begin
            w_state_nxt = S_EMPTY;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Outputs. Everything below is a function of registered state, so the
   // half on the bus holds steady while the consumer stalls.
   // -------------------------------------------------------------------------
   assign w_half_sel = (r_state == S_FIRST) ? MSB_FIRST : ~MSB_FIRST;

   always_comb begin
      out_data = '0;
      out_half = 1'b0;
      out_last = 1'b0;
      if (w_busy) begin
         out_half = w_half_sel;
         out_last = (r_state == S_SECOND);
         out_data = w_half_sel ? r_cur[2*NBITS-1:NBITS] : r_cur[NBITS-1:0];
      end
   end

   assign out_valid  = w_busy;
   assign in_ready   = ~r_pend_valid;
   assign word_count = r_word_count;

endmodule

// File: tb/tb_half_word_serializer.sv
// Bench for half_word_serializer. Two instances share the same stimulus:
// dut0 emits msb first, dut1 lsb first. A queue model of the expected halves
// is checked every cycle; directed sequences add literal expectations.
module tb_half_word_serializer;

   localparam int NB = 7;

   logic          clk = 1'b0;
   logic          rst;
   logic [13:0]   in_data;
   logic          in_valid;
   logic          out_ready;

   logic          in_ready0, out_valid0, out_half0, out_last0;
   logic [NB-1:0] out_data0;
   logic [15:0]   word_count0;
   logic          in_ready1, out_valid1, out_half1, out_last1;
   logic [NB-1:0] out_data1;
   logic [15:0]   word_count1;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   // model: one entry per half still to be emitted, {is_second, word}
   logic [14:0] q[$];
   logic [15:0] mcnt = 16'd0;

   always #5 clk = ~clk;

   half_word_serializer #(.NBITS(NB), .MSB_FIRST(1'b1)) dut0 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready0), .out_data(out_data0), .out_valid(out_valid0),
      .out_ready(out_ready), .out_half(out_half0), .out_last(out_last0),
      .word_count(word_count0));

   half_word_serializer #(.NBITS(NB), .MSB_FIRST(1'b0)) dut1 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready1), .out_data(out_data1), .out_valid(out_valid1),
      .out_ready(out_ready), .out_half(out_half1), .out_last(out_last1),
      .word_count(word_count1));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // expected {last, half, data} for a queued half, given the emit order
   function automatic logic [8:0] exp_out(input logic [14:0] e, input bit msb_first);
      logic h;
      logic [6:0] d;
      h = e[14] ? ~msb_first : msb_first;
      d = h ? e[13:7] : e[6:0];
      return {e[14], h, d};
   endfunction

   // per-cycle compare against the model, then advance the model by one edge
   always @(negedge clk) begin
      if (chk_en) begin
         automatic int n = q.size();
         automatic logic [8:0] e0 = 9'd0;
         automatic logic [8:0] e1 = 9'd0;
         automatic bit oacc, iacc;
         if (n > 0) begin
            e0 = exp_out(q[0], 1'b1);
            e1 = exp_out(q[0], 1'b0);
         end
         chk("m0_valid", out_valid0, n > 0);
         chk("m0_ready", in_ready0, n <= 2);
         chk("m0_out",   {out_last0, out_half0, out_data0}, e0);
         chk("m0_count", word_count0, mcnt);
         chk("m1_valid", out_valid1, n > 0);
         chk("m1_ready", in_ready1, n <= 2);
         chk("m1_out",   {out_last1, out_half1, out_data1}, e1);
         chk("m1_count", word_count1, mcnt);
         if (rst) begin
            q.delete();
            mcnt = 16'd0;
         end else begin
            oacc = (n > 0) && out_ready;
            iacc = in_valid && (n <= 2);
            if (oacc) begin
               if (q[0][14]) mcnt = mcnt + 16'd1;
               void'(q.pop_front());
            end
            if (iacc) begin
               q.push_back({1'b0, in_data});
               q.push_back({1'b1, in_data});
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      step();
      rst = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [6:0]  exp_s[6];
      logic [6:0]  exp_b[6];
      logic [13:0] words[3];
      int wi;
      bit w2acc;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      step();
      chk_en = 1'b1;
      step();
      rst = 1'b0;

      // reset values
      chk("rst_valid", out_valid0, 0);
      chk("rst_ready", in_ready0, 1);
      chk("rst_data",  {out_last0, out_half0, out_data0}, 0);
      chk("rst_count", word_count0, 0);

      // single word, both orders
      in_data = 14'h2A55; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("w1_first0", {out_valid0, out_last0, out_half0, out_data0}, {3'b101, 7'h54});
      chk("w1_first1", {out_valid1, out_last1, out_half1, out_data1}, {3'b100, 7'h55});
      step();
      chk("w1_sec0", {out_valid0, out_last0, out_half0, out_data0}, {3'b110, 7'h55});
      chk("w1_sec1", {out_valid1, out_last1, out_half1, out_data1}, {3'b111, 7'h54});
      step();
      chk("w1_idle",  out_valid0, 0);
      chk("w1_count", word_count0, 1);

      // streaming: in_valid held, out_ready high, no gaps
      do_reset();
      words[0] = 14'h0001; words[1] = 14'h3FFF; words[2] = 14'h1234;
      exp_s[0] = 7'h00; exp_s[1] = 7'h01; exp_s[2] = 7'h7F;
      exp_s[3] = 7'h7F; exp_s[4] = 7'h24; exp_s[5] = 7'h34;
      out_ready = 1'b1; in_data = words[0]; in_valid = 1'b1;
      step();
      wi = 1;
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("str_half%0d", k), {out_valid0, out_data0}, {1'b1, exp_s[k]});
         if (k == 1) chk("str_rdy_lo", in_ready0, 0);
         if (k == 2) chk("str_rdy_hi", in_ready0, 1);
         if (wi < 3) begin
            in_data = words[wi]; in_valid = 1'b1;
            if (in_ready0) wi++;
         end else begin
            in_valid = 1'b0;
         end
         step();
      end
      in_valid = 1'b0;
      chk("str_idle",  out_valid0, 0);
      chk("str_count", word_count0, 3);

      // backpressure: consumer stalls for 5 cycles
      do_reset();
      out_ready = 1'b0; in_data = 14'h2A55; in_valid = 1'b1;
      step();
      in_data = 14'h1234;
      step();
      in_data = 14'h0F0F;
      for (int k = 0; k < 4; k++) begin
         chk("bp_hold", {out_valid0, out_last0, out_half0, out_data0}, {3'b101, 7'h54});
         chk("bp_rdy",  in_ready0, 0);
         step();
      end
      exp_b[0] = 7'h54; exp_b[1] = 7'h55; exp_b[2] = 7'h24;
      exp_b[3] = 7'h34; exp_b[4] = 7'h1E; exp_b[5] = 7'h0F;
      out_ready = 1'b1;
      w2acc = 1'b0;
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("bp_half%0d", k), {out_valid0, out_data0}, {1'b1, exp_b[k]});
         if (!w2acc) begin
            if (in_ready0) w2acc = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         step();
      end
      in_valid = 1'b0;
      chk("bp_idle",  out_valid0, 0);
      chk("bp_count", word_count0, 3);

      // reset in SECOND with a word pending
      do_reset();
      out_ready = 1'b0; in_data = 14'h2A55; in_valid = 1'b1;
      step();
      in_data = 14'h1234;
      step();
      in_valid = 1'b0; out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("mr_state", {out_valid0, out_last0, in_ready0}, 3'b110);
      rst = 1'b1;
      step();
      rst = 1'b0; out_ready = 1'b1;
      chk("mr_valid", out_valid0, 0);
      chk("mr_ready", in_ready0, 1);
      chk("mr_count", word_count0, 0);
      step();
      chk("mr_quiet", {out_valid0, out_data0}, 0);
      in_data = 14'h3F80; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("mr_new0", {out_valid0, out_half0, out_data0}, {2'b11, 7'h7F});
      step();
      chk("mr_new1", {out_valid0, out_last0, out_data0}, {2'b11, 7'h00});
      step();
      chk("mr_new_count", word_count0, 1);

      // counter wrap, counter preloaded to FFFE while idle
      do_reset();
      force dut0.r_word_count = 16'hFFFE;
      force dut1.r_word_count = 16'hFFFE;
      mcnt = 16'hFFFE;
      step();
      release dut0.r_word_count;
      release dut1.r_word_count;
      step();
      chk("wrap_pre", word_count0, 16'hFFFE);
      out_ready = 1'b1; in_data = 14'h1111; in_valid = 1'b1;
      step();
      in_data = 14'h2222;
      step();
      in_valid = 1'b0;
      step();
      chk("wrap_ffff", word_count0, 16'hFFFF);
      step();
      step();
      chk("wrap_zero", {out_valid0, word_count0}, 17'd0);
      chk("wrap_zero1", word_count1, 16'd0);

      step();
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
